// File: rtl/kamacore_stage_id.sv
// Instruction decode stage: field extraction, immediate generation, 2R/1W register file
// with write-through bypass, load-use interlock and the ID/EX pipeline register.
module kamacore_stage_id #(
  parameter int CPU_WIDTH = 32,
  parameter int REG_COUNT = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 branch_valid,
  input  logic                 if_valid,
  input  logic [CPU_WIDTH-1:0] if_instruction,
  output logic                 id_ready,
  input  logic                 ex_stall,
  input  logic                 wb_we,
  input  logic [4:0]           wb_rd,
  input  logic [CPU_WIDTH-1:0] wb_data,
  output logic                 ex_valid,
  output logic [6:0]           ex_opcode,
  output logic [4:0]           ex_rd,
  output logic [4:0]           ex_rs1,
  output logic [4:0]           ex_rs2,
  output logic [CPU_WIDTH-1:0] ex_rs1_data,
  output logic [CPU_WIDTH-1:0] ex_rs2_data,
  output logic [CPU_WIDTH-1:0] ex_imm
);

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  // Fields are packed into the top bits and arithmetic-shifted down for sign extension.
  function automatic logic signed [CPU_WIDTH-1:0] imm_gen(input logic [31:0] ins);
    logic signed [31:0] s;
    case (ins[6:0])
      OP_LOAD, OP_IMM, OP_JALR: s = $signed(ins) >>> 20;
      OP_STORE:                 s = $signed({ins[31:25], ins[11:7], 20'b0}) >>> 20;
      OP_BRANCH:                s = $signed({ins[31], ins[7], ins[30:25], ins[11:8], 20'b0}) >>> 19;
      OP_LUI, OP_AUIPC:         s = $signed({ins[31:12], 12'b0});
      OP_JAL:                   s = $signed({ins[31], ins[19:12], ins[20], ins[30:21], 12'b0}) >>> 11;
      default:                  s = '0;
    endcase
    return CPU_WIDTH'(s);
  endfunction

  logic [CPU_WIDTH-1:0] r_regs [REG_COUNT];

  logic [6:0]           w_opcode;
  logic [4:0]           w_rd, w_rs1, w_rs2;
  logic [CPU_WIDTH-1:0] w_rs1_data, w_rs2_data, w_imm;
  logic                 w_hazard;

  logic                 r_vld_p1;
  logic [6:0]           r_opcode_p1;
  logic [4:0]           r_rd_p1, r_rs1_p1, r_rs2_p1;
  logic [CPU_WIDTH-1:0] r_rs1_data_p1, r_rs2_data_p1, r_imm_p1;

  assign w_opcode = if_instruction[6:0];
  assign w_rd     = if_instruction[11:7];
  assign w_rs1    = if_instruction[19:15];
  assign w_rs2    = if_instruction[24:20];
  assign w_imm    = imm_gen(if_instruction[31:0]);

  // x0 is hardwired; a same-cycle writeback to the read index wins over the array.
  always_comb begin
    w_rs1_data = '0;
    w_rs2_data = '0;
    if (w_rs1 != 5'd0) w_rs1_data = (wb_we && wb_rd == w_rs1) ? wb_data : r_regs[w_rs1];
    if (w_rs2 != 5'd0) w_rs2_data = (wb_we && wb_rd == w_rs2) ? wb_data : r_regs[w_rs2];
  end

  assign w_hazard = r_vld_p1 && (r_opcode_p1 == OP_LOAD) && (r_rd_p1 != 5'd0) && if_valid &&
                    ((r_rd_p1 == w_rs1) || (r_rd_p1 == w_rs2));

  // Flush lets fetch advance even when execute is stalled or a hazard is pending.
  always_comb begin
    id_ready = 1'b1;
    if (rst)               id_ready = 1'b0;
    else if (branch_valid) id_ready = 1'b1;
    else if (ex_stall)     id_ready = 1'b0;
    else if (w_hazard)     id_ready = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < REG_COUNT; i++) r_regs[i] <= '0;
    end else if (wb_we && wb_rd != 5'd0) begin
      r_regs[wb_rd] <= wb_data;
    end
  end

  // ---- ID -> EX boundary (p1) ----
  always_ff @(posedge clk) begin
    if (rst) begin
      r_vld_p1      <= 1'b0;
      r_opcode_p1   <= '0;
      r_rd_p1       <= '0;
      r_rs1_p1      <= '0;
      r_rs2_p1      <= '0;
      r_rs1_data_p1 <= '0;
      r_rs2_data_p1 <= '0;
      r_imm_p1      <= '0;
    end else if (branch_valid) begin
      r_vld_p1 <= 1'b0;
    end else if (!ex_stall) begin
      if (w_hazard) begin
        r_vld_p1 <= 1'b0;
      end else begin
        r_vld_p1 <= if_valid;
        if (if_valid) begin
          r_opcode_p1   <= w_opcode;
          r_rd_p1       <= w_rd;
          r_rs1_p1      <= w_rs1;
          r_rs2_p1      <= w_rs2;
          r_rs1_data_p1 <= w_rs1_data;
          r_rs2_data_p1 <= w_rs2_data;
          r_imm_p1      <= w_imm;
        end
      end
    end
  end

  assign ex_valid    = r_vld_p1;
  assign ex_opcode   = r_opcode_p1;
  assign ex_rd       = r_rd_p1;
  assign ex_rs1      = r_rs1_p1;
  assign ex_rs2      = r_rs2_p1;
  assign ex_rs1_data = r_rs1_data_p1;
  assign ex_rs2_data = r_rs2_data_p1;
  assign ex_imm      = r_imm_p1;

endmodule

// File: tb/tb_kamacore_stage_id.sv
// Scoreboard bench for kamacore_stage_id: expected ID/EX contents are queued at issue
// and popped when the instruction appears on the ex_* outputs.
module tb_kamacore_stage_id;

  logic        clk = 1'b0;
  logic        rst, branch_valid, if_valid, ex_stall, wb_we;
  logic [31:0] if_instruction, wb_data;
  logic [4:0]  wb_rd;
  logic        id_ready, ex_valid;
  logic [6:0]  ex_opcode;
  logic [4:0]  ex_rd, ex_rs1, ex_rs2;
  logic [31:0] ex_rs1_data, ex_rs2_data, ex_imm;

  kamacore_stage_id #(.CPU_WIDTH(32), .REG_COUNT(32)) dut (
    .clk(clk), .rst(rst), .branch_valid(branch_valid), .if_valid(if_valid),
    .if_instruction(if_instruction), .id_ready(id_ready), .ex_stall(ex_stall),
    .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data), .ex_valid(ex_valid),
    .ex_opcode(ex_opcode), .ex_rd(ex_rd), .ex_rs1(ex_rs1), .ex_rs2(ex_rs2),
    .ex_rs1_data(ex_rs1_data), .ex_rs2_data(ex_rs2_data), .ex_imm(ex_imm)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        vld;
    logic [6:0]  op;
    logic [4:0]  rd, rs1, rs2;
    logic [31:0] d1, d2, imm;
  } exp_t;

  exp_t        exp_q[$];
  exp_t        e, snap;
  logic [31:0] m_regs [32];
  int          n_cmp = 0;
  int          n_bad = 0;

  function automatic logic [31:0] m_imm(input logic [31:0] i);
    case (i[6:0])
      7'h03, 7'h13, 7'h67: return {{20{i[31]}}, i[31:20]};
      7'h23:               return {{20{i[31]}}, i[31:25], i[11:7]};
      7'h63:               return {{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
      7'h37, 7'h17:        return {i[31:12], 12'h000};
      7'h6F:               return {{11{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
      default:             return 32'h0;
    endcase
  endfunction

  function automatic logic [31:0] m_read(input logic [4:0] a);
    if (a == 5'd0) return 32'h0;
    if (wb_we && wb_rd == a) return wb_data;
    return m_regs[a];
  endfunction

  function automatic exp_t obs();
    return {ex_valid, ex_opcode, ex_rd, ex_rs1, ex_rs2, ex_rs1_data, ex_rs2_data, ex_imm};
  endfunction

  task automatic push(input logic [31:0] i);
    exp_t x;
    x.vld = 1'b1; x.op = i[6:0]; x.rd = i[11:7]; x.rs1 = i[19:15]; x.rs2 = i[24:20];
    x.d1 = m_read(i[19:15]); x.d2 = m_read(i[24:20]); x.imm = m_imm(i);
    exp_q.push_back(x);
  endtask

  task automatic pop();
    if (exp_q.size() != 0) e = exp_q.pop_front(); else e = '0;
  endtask

  // Advance one clock; the register model follows writeback using the values held across the edge.
  task automatic tick();
    @(posedge clk);
    if (rst) begin
      for (int k = 0; k < 32; k++) m_regs[k] = 32'h0;
    end else if (wb_we && wb_rd != 5'd0) begin
      m_regs[wb_rd] = wb_data;
    end
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; branch_valid = 1'b1; ex_stall = 1'b0; if_valid = 1'b1;
    if_instruction = 32'h0002_8313; wb_we = 1'b1; wb_rd = 5'd5; wb_data = 32'hAAAA_AAAA;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      n_cmp++; if (id_ready !== 1'b0) begin n_bad++; $display("FAIL reset_ready[%0d]: got %b want 0", c, id_ready); end
      tick();
    end
    n_cmp++; if (obs() !== exp_t'(0)) begin n_bad++; $display("FAIL reset_state: got %h want 0", obs()); end
  endtask

  task automatic test_decode();
    rst = 1'b0; branch_valid = 1'b0; if_valid = 1'b1; if_instruction = 32'h00A0_0093;
    wb_we = 1'b1; wb_rd = 5'd5; wb_data = 32'h0000_1234;
    @(negedge clk);
    n_cmp++; if (id_ready !== 1'b1) begin n_bad++; $display("FAIL first_accept_ready: got %b want 1", id_ready); end
    push(if_instruction); tick(); pop();
    n_cmp++; if (obs() !== e) begin n_bad++; $display("FAIL first_accept: got %h want %h", obs(), e); end
    wb_we = 1'b0; if_instruction = 32'h0002_8313;
    @(negedge clk); push(if_instruction); tick(); pop();
    n_cmp++; if (obs() !== e) begin n_bad++; $display("FAIL addi_x6: got %h want %h", obs(), e); end
    n_cmp++;
    if (!(ex_valid === 1'b1 && ex_rd === 5'd6 && ex_rs1_data === 32'h0000_1234 && ex_imm === 32'h0)) begin
      n_bad++; $display("FAIL addi_x6_fields: got v=%b rd=%0d d1=%h imm=%h want v=1 rd=6 d1=00001234 imm=0",
                        ex_valid, ex_rd, ex_rs1_data, ex_imm);
    end
  endtask

  task automatic test_bypass();
    wb_we = 1'b1; wb_rd = 5'd7; wb_data = 32'hDEAD_BEEF; if_instruction = 32'h0003_8493;
    @(negedge clk); push(if_instruction); tick(); pop();
    n_cmp++; if (obs() !== e) begin n_bad++; $display("FAIL bypass: got %h want %h", obs(), e); end
    n_cmp++; if (ex_rs1_data !== 32'hDEAD_BEEF) begin n_bad++; $display("FAIL bypass_data: got %h want deadbeef", ex_rs1_data); end
    wb_rd = 5'd0; wb_data = 32'hFFFF_FFFF; if_instruction = 32'h0000_0533;
    @(negedge clk); push(if_instruction); tick(); pop();
    n_cmp++; if (obs() !== e) begin n_bad++; $display("FAIL x0_same_cycle: got %h want %h", obs(), e); end
    wb_we = 1'b0; if_instruction = 32'h0070_0533;
    @(negedge clk); push(if_instruction); tick(); pop();
    n_cmp++;
    if (ex_rs1_data !== 32'h0 || ex_rs2_data !== 32'hDEAD_BEEF) begin
      n_bad++; $display("FAIL x0_after_write: got d1=%h d2=%h want d1=0 d2=deadbeef", ex_rs1_data, ex_rs2_data);
    end
  endtask

  task automatic test_load_use();
    if_instruction = 32'h0002_8403;
    @(negedge clk); push(if_instruction); tick(); pop();
    n_cmp++; if (obs() !== e) begin n_bad++; $display("FAIL load_issue: got %h want %h", obs(), e); end
    if_instruction = 32'h0080_05B3;
    @(negedge clk);
    n_cmp++; if (id_ready !== 1'b0) begin n_bad++; $display("FAIL hazard_ready: got %b want 0", id_ready); end
    tick();
    n_cmp++; if (ex_valid !== 1'b0) begin n_bad++; $display("FAIL hazard_bubble: got %b want 0", ex_valid); end
    @(negedge clk);
    n_cmp++; if (id_ready !== 1'b1) begin n_bad++; $display("FAIL hazard_release: got %b want 1", id_ready); end
    push(if_instruction); tick(); pop();
    n_cmp++; if (obs() !== e) begin n_bad++; $display("FAIL add_after_bubble: got %h want %h", obs(), e); end
  endtask

  task automatic test_stall_flush();
    snap = obs(); ex_stall = 1'b1; if_instruction = 32'h0010_0613;
    @(negedge clk);
    n_cmp++; if (id_ready !== 1'b0) begin n_bad++; $display("FAIL stall_ready_c1: got %b want 0", id_ready); end
    tick();
    n_cmp++; if (obs() !== snap) begin n_bad++; $display("FAIL stall_hold_c1: got %h want %h", obs(), snap); end
    branch_valid = 1'b1;
    @(negedge clk);
    n_cmp++; if (id_ready !== 1'b1) begin n_bad++; $display("FAIL flush_ready: got %b want 1", id_ready); end
    tick();
    n_cmp++; if (ex_valid !== 1'b0) begin n_bad++; $display("FAIL flush_bubble: got %b want 0", ex_valid); end
    branch_valid = 1'b0;
    @(negedge clk);
    n_cmp++; if (id_ready !== 1'b0) begin n_bad++; $display("FAIL stall_ready_c3: got %b want 0", id_ready); end
    tick();
    n_cmp++; if (ex_valid !== 1'b0) begin n_bad++; $display("FAIL stall_hold_c3: got %b want 0", ex_valid); end
    ex_stall = 1'b0;
    @(negedge clk); push(if_instruction); tick(); pop();
    n_cmp++; if (obs() !== e) begin n_bad++; $display("FAIL after_stall: got %h want %h", obs(), e); end
  endtask

  task automatic test_back_to_back_imm();
    logic [31:0] words [5];
    logic [31:0] imms  [5];
    words = '{32'hFFF0_0093, 32'h8000_006F, 32'h1234_5037, 32'hFE51_2E23, 32'hFE20_8CE3};
    imms  = '{32'hFFFF_FFFF, 32'hFFF0_0000, 32'h1234_5000, 32'hFFFF_FFFC, 32'hFFFF_FFF8};
    for (int i = 0; i < 5; i++) begin
      if_instruction = words[i];
      @(negedge clk);
      n_cmp++; if (id_ready !== 1'b1) begin n_bad++; $display("FAIL b2b_ready[%0d]: got %b want 1", i, id_ready); end
      push(if_instruction); tick(); pop();
      n_cmp++; if (obs() !== e) begin n_bad++; $display("FAIL b2b[%0d]: got %h want %h", i, obs(), e); end
      n_cmp++; if (ex_imm !== imms[i]) begin n_bad++; $display("FAIL imm[%0d]: got %h want %h", i, ex_imm, imms[i]); end
    end
  endtask

  task automatic test_random();
    logic [6:0]  ops [9];
    logic [31:0] ins;
    logic        m_vld, haz, exp_v;
    logic [6:0]  m_op;
    logic [4:0]  m_rd;
    ops = '{7'h03, 7'h13, 7'h67, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6F, 7'h33};
    branch_valid = 1'b1; if_valid = 1'b1;
    @(negedge clk); tick();
    n_cmp++; if (ex_valid !== 1'b0) begin n_bad++; $display("FAIL rand_flush: got %b want 0", ex_valid); end
    branch_valid = 1'b0; m_vld = 1'b0; m_op = '0; m_rd = '0;
    for (int n = 0; n < 40; n++) begin
      ins = $urandom;
      ins[24:20] = 5'($urandom_range(0, 7));
      ins[19:15] = 5'($urandom_range(0, 7));
      ins[11:7]  = 5'($urandom_range(0, 7));
      ins[6:0]   = ops[$urandom_range(0, 8)];
      if_instruction = ins; if_valid = ($urandom_range(0, 3) != 0);
      wb_we = 1'($urandom_range(0, 1)); wb_rd = 5'($urandom_range(0, 7)); wb_data = $urandom;
      @(negedge clk);
      haz = m_vld && m_op == 7'h03 && m_rd != 5'd0 && if_valid && (m_rd == ins[19:15] || m_rd == ins[24:20]);
      n_cmp++; if (id_ready !== !haz) begin n_bad++; $display("FAIL rand_ready[%0d]: got %b want %b", n, id_ready, !haz); end
      exp_v = !haz && if_valid;
      if (exp_v) push(ins);
      tick();
      n_cmp++; if (ex_valid !== exp_v) begin n_bad++; $display("FAIL rand_valid[%0d]: got %b want %b", n, ex_valid, exp_v); end
      if (exp_v) begin
        pop();
        n_cmp++; if (obs() !== e) begin n_bad++; $display("FAIL rand_data[%0d]: got %h want %h", n, obs(), e); end
        m_op = ins[6:0]; m_rd = ins[11:7];
      end
      m_vld = exp_v;
    end
    wb_we = 1'b0; if_valid = 1'b1;
  endtask

  task automatic test_reset_mid_stall();
    if_instruction = 32'h0002_8313;
    @(negedge clk); push(if_instruction); tick(); pop();
    n_cmp++; if (obs() !== e) begin n_bad++; $display("FAIL pre_stall: got %h want %h", obs(), e); end
    ex_stall = 1'b1;
    @(negedge clk); tick();
    rst = 1'b1; branch_valid = 1'b1; wb_we = 1'b1; wb_rd = 5'd5; wb_data = 32'h5555_5555;
    @(negedge clk);
    n_cmp++; if (id_ready !== 1'b0) begin n_bad++; $display("FAIL rst_ready: got %b want 0", id_ready); end
    tick();
    n_cmp++; if (obs() !== exp_t'(0)) begin n_bad++; $display("FAIL rst_mid_stall: got %h want 0", obs()); end
    rst = 1'b0; ex_stall = 1'b0; branch_valid = 1'b0; wb_we = 1'b0; if_instruction = 32'h0072_8533;
    @(negedge clk);
    n_cmp++; if (id_ready !== 1'b1) begin n_bad++; $display("FAIL rst_release_ready: got %b want 1", id_ready); end
    push(if_instruction); tick(); pop();
    n_cmp++; if (obs() !== e) begin n_bad++; $display("FAIL regs_cleared: got %h want %h", obs(), e); end
    n_cmp++;
    if (ex_rs1_data !== 32'h0 || ex_rs2_data !== 32'h0) begin
      n_bad++; $display("FAIL regs_zero: got d1=%h d2=%h want 0 0", ex_rs1_data, ex_rs2_data);
    end
  endtask

  initial begin
    for (int k = 0; k < 32; k++) m_regs[k] = 32'h0;
    test_reset();
    test_decode();
    test_bypass();
    test_load_use();
    test_stall_flush();
    test_back_to_back_imm();
    test_random();
    test_reset_mid_stall();
    if_valid = 1'b0;
    @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule

// File: doc/kamacore_stage_id.md
KAMACORE_STAGE_ID -- requirements
Module: kamacore_stage_id

Interface
REQ-001 Parameter: CPU_WIDTH, 32, instruction and register data width.
REQ-002 Parameter: REG_COUNT, 32, architectural registers; index width 5.
REQ-003 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-004 Port: rst  input  1  reset, synchronous, active-high.
REQ-005 Port: branch_valid  input  1  taken-branch flush request from execute.
REQ-006 Port: if_valid  input  1  instruction word on if_instruction is valid.
REQ-007 Port: if_instruction  input  CPU_WIDTH  instruction word from the fetch stage.
REQ-008 Port: id_ready  output  1  instruction accepted this cycle; fetch holds its word when 0.
REQ-009 Port: ex_stall  input  1  execute cannot accept; ID/EX register holds.
REQ-010 Port: wb_we, wb_rd, wb_data  input  1/5/CPU_WIDTH  register file write from writeback.
REQ-011 Port: ex_valid  output  1  ID/EX register holds a live instruction.
REQ-012 Port: ex_opcode, ex_rd, ex_rs1, ex_rs2  output  7/5/5/5  decoded fields, registered.
REQ-013 Port: ex_rs1_data, ex_rs2_data, ex_imm  output  CPU_WIDTH each  operands and immediate, registered.

Function
REQ-014 Fields: opcode=[6:0], rd=[11:7], rs1=[19:15], rs2=[24:20].
REQ-015 Immediate, sign-extended from bit 31, selected by opcode:
- I (0000011, 0010011, 1100111): [31:20].
- S (0100011): {[31:25],[11:7]}.
- B (1100011): {[31],[7],[30:25],[11:8],0}.
- U (0110111, 0010111): {[31:12], 12'b0}.
- J (1101111): {[31],[19:12],[20],[30:21],0}.
- All other opcodes: 0.
REQ-016 Register file: REG_COUNT x CPU_WIDTH, two combinational read ports (rs1, rs2), one synchronous write port.
REQ-017 Register 0 reads 0 always; writes with wb_rd=0 are ignored.
REQ-018 Write-through bypass: wb_we=1 and wb_rd equal to a nonzero read index in the same cycle returns wb_data on that read.
REQ-019 Latency: an instruction accepted in cycle N appears on ex_* with ex_valid=1 in cycle N+1.
REQ-020 Load-use hazard when all hold: ex_valid=1; ex_opcode=0000011; ex_rd!=0; if_valid=1; ex_rd equals if_instruction rs1 or rs2.
REQ-021 On a hazard with ex_stall=0: id_ready=0; at the next edge ex_valid<=0 (bubble) and the fetched word is not consumed.
REQ-022 ex_stall=1 and branch_valid=0: all ex_* registers hold; id_ready=0.
REQ-023 branch_valid=1: at the next edge ex_valid<=0 and the incoming word is discarded.
REQ-024 branch_valid overrides ex_stall and hazard; id_ready=1 in that cycle so fetch advances.
REQ-025 Otherwise id_ready=1. At the edge: ex_valid<=if_valid; ex_* load decoded fields and operands when if_valid=1.
REQ-026 While ex_valid=0, ex_* data outputs are don't-care, except after reset (REQ-028).
REQ-027 Register file writes occur whenever wb_we=1, independent of stall, flush or hazard.

Reset
REQ-028 rst=1 at a rising edge: ex_valid, ex_opcode, ex_rd, ex_rs1, ex_rs2, ex_rs1_data, ex_rs2_data, ex_imm <= 0; all registers <= 0.
REQ-029 While rst=1: id_ready=0 and wb writes are ignored.
REQ-030 Reset overrides branch_valid, ex_stall and hazard, including mid-stall and mid-flush.
REQ-031 First acceptance is possible in the first cycle after rst falls.

Verification
REQ-032 Write x5=0x0000_1234, then decode 0x0002_8313 (addi x6,x5,0) -> next cycle ex_valid=1, ex_rd=6, ex_rs1_data=0x1234, ex_imm=0.
REQ-033 Same cycle: wb_we=1, wb_rd=7, wb_data=0xDEAD_BEEF; decode rs1=7 -> ex_rs1_data=0xDEAD_BEEF (bypass); write to x0 -> x0 still reads 0.
REQ-034 Load (rd=8) in EX; decode add using rs2=8 -> id_ready=0, one bubble (ex_valid=0); the add issues the following cycle with the same operands.
REQ-035 ex_stall=1 for 3 cycles with a live instruction -> ex_* unchanged and id_ready=0 throughout; branch_valid=1 in cycle 2 -> ex_valid=0 next cycle, id_ready=1.
REQ-036 Immediate checks:
- 0xFFF0_0093 -> ex_imm=0xFFFF_FFFF.
- 0x8000_006F -> ex_imm=0xFFF0_0000.
- 0x1234_5037 -> ex_imm=0x1234_5000.
REQ-037 Assert rst mid-stall -> next cycle all ex_* and registers 0, id_ready=0; released -> acceptance next cycle.
